write_dac: RTL and testbench

WRITE_DAC -- requirements
Module: write_dac

---
 rtl/dac_pkg.sv | 21 ++
 rtl/write_dac_if.sv | 32 +++
 rtl/dac_fifo.sv | 79 +++++++
 rtl/write_dac.sv | 108 ++++++++++
 tb/tb_write_dac.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_pkg.sv
// -----------------------------------------------------------------------------
// dac_pkg
// Shared defaults for the DAC write path and the matching ADC read-side
// blocks: sample width, DAC clock divider, FIFO depth and the idle
// (mid-scale) code.
// Ports: none (package).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package dac_pkg;

    localparam int DAC_DATA_W = 12;              // sample / DAC bus width
    localparam int DAC_DIV    = 4;               // clk_400M cycles per dac_clk period
    localparam int DAC_DEPTH  = 4;               // sample FIFO depth
    localparam logic [11:0] DAC_IDLE_CODE = 12'd2048; // offset-binary mid-scale

    // Width of a counter that has to hold 0..div-1 (never less than 1 bit).
    function automatic int phase_w(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/write_dac_if.sv
// -----------------------------------------------------------------------------
// write_dac_if
// Sample handshake between a producer and the DAC writer.
//   sample_in    : offset-binary sample
//   sample_valid : sample_in is valid this cycle
//   sample_ready : consumer accepts a sample this cycle
// Modports: master = producer, slave = write_dac.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface write_dac_if
    import dac_pkg::*;
#(
    parameter int DATA_W = DAC_DATA_W
) ();

    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample_in,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/dac_fifo.sv
// -----------------------------------------------------------------------------
// dac_fifo
// Single-clock first-word-fall-through sample FIFO. The head entry is visible
// combinationally on head so the DAC slot logic can load it on the same edge
// that pops it.
// Ports:
//   clk_400M, rst    : clock, asynchronous active-high reset
//   push, push_data  : write request (ignored when full, even if popping)
//   pop              : read request (ignored when empty)
//   head             : oldest entry
//   full, empty      : occupancy flags
//   level            : occupancy 0..DEPTH
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module dac_fifo
    import dac_pkg::*;
#(
    parameter int DATA_W = DAC_DATA_W,
    parameter int DEPTH  = DAC_DEPTH
) (
    input  logic                       clk_400M,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [LW-1:0]     level_reg;
    logic              do_push;
    logic              do_pop;

    assign full    = (level_reg == LW'(DEPTH));
    assign empty   = (level_reg == '0);
    // Accept decisions use the flags from before this edge, so a full FIFO
    // refuses a push even when a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_reg];
    assign level   = level_reg;

    // Storage has no reset: contents are meaningless once the pointers clear.
    always_ff @(posedge clk_400M) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk_400M or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/write_dac.sv
// -----------------------------------------------------------------------------
// write_dac
// Buffers producer samples in a small FIFO and presents them to a parallel
// DAC. A phase counter divides clk_400M by DIV to make dac_clk; dac_data only
// changes on the dac_clk falling edge ("update slot"), giving DIV/2 cycles of
// setup before the DAC latches on the rising edge.
// Ports:
//   clk_400M, rst  : clock, asynchronous active-high reset
//   en             : 1 = pop samples to the DAC, 0 = drive IDLE_CODE
//   smp            : sample handshake (slave side)
//   underflow_clr  : clears the sticky underflow flag
//   dac_clk        : registered DAC sample clock
//   dac_data       : registered DAC data bus
//   fifo_level     : FIFO occupancy
//   underflow      : sticky, set when an enabled slot finds the FIFO empty
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module write_dac
    import dac_pkg::*;
#(
    parameter int                DATA_W    = DAC_DATA_W,
    parameter int                DIV       = DAC_DIV,
    parameter int                DEPTH     = DAC_DEPTH,
    parameter logic [DATA_W-1:0] IDLE_CODE = DATA_W'(DAC_IDLE_CODE)
) (
    input  logic                   clk_400M,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   underflow_clr,
    write_dac_if.slave             smp,
    output logic                   dac_clk,
    output logic [DATA_W-1:0]      dac_data,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   underflow
);

    localparam int              CNT_W    = phase_w(DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2);

    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic              dac_clk_reg;
    logic [DATA_W-1:0] dac_data_reg;
    logic              underflow_reg;
    logic              slot;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    assign cnt_next = (cnt_reg == CNT_MAX) ? '0 : cnt_reg + 1'b1;
    // The edge on which the counter returns to 0 is the update slot.
    assign slot     = (cnt_reg == CNT_MAX);
    // Emptiness is judged before this edge: a sample pushed on the slot edge
    // itself is not popped until the following slot.
    assign fifo_pop = slot && en && !fifo_empty;

    assign smp.sample_ready = !fifo_full;

    dac_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_400M  (clk_400M),
        .rst       (rst),
        .push      (smp.sample_valid),
        .push_data (smp.sample_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk_400M or posedge rst) begin
        if (rst) begin
            cnt_reg       <= '0;
            dac_clk_reg   <= 1'b0;
            dac_data_reg  <= IDLE_CODE;
            underflow_reg <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            // Derived from the next count so clock and counter move together.
            dac_clk_reg <= (cnt_next >= CNT_HALF);

            if (slot) begin
                if (!en) begin
                    dac_data_reg <= IDLE_CODE;
                end else if (!fifo_empty) begin
                    dac_data_reg <= fifo_head;
                end
            end

            // Set has priority over clear.
            if (slot && en && fifo_empty) begin
                underflow_reg <= 1'b1;
            end else if (underflow_clr) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    assign dac_clk   = dac_clk_reg;
    assign dac_data  = dac_data_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_write_dac.sv
`timescale 1ns/1ps
module tb_write_dac;

    logic        clk_400M = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        underflow_clr = 1'b0;
    logic        dac_clk;
    logic [11:0] dac_data;
    logic [2:0]  fifo_level;
    logic        underflow;

    int checks = 0;
    int errors = 0;
    int ph = 0;   // expected phase counter value after the last edge

    write_dac_if #(.DATA_W(12)) smp_if ();

    write_dac #(
        .DATA_W    (12),
        .DIV       (4),
        .DEPTH     (4),
        .IDLE_CODE (12'd2048)
    ) dut (
        .clk_400M      (clk_400M),
        .rst           (rst),
        .en            (en),
        .underflow_clr (underflow_clr),
        .smp           (smp_if),
        .dac_clk       (dac_clk),
        .dac_data      (dac_data),
        .fifo_level    (fifo_level),
        .underflow     (underflow)
    );

    always #1.25 clk_400M = ~clk_400M;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_400M);
        #0.5;
        ph = (ph + 1) % 4;
    endtask

    task automatic align(input int p);
        while (ph != p) tick();
    endtask

    task automatic test_reset();
        smp_if.sample_valid = 1'b0;
        smp_if.sample_in    = 12'h000;
        #0.3 rst = 1'b1;
        #0.2;
        checks++; if (dac_clk !== 1'b0) begin errors++; $display("FAIL rst_dac_clk: got %0b expected 0", dac_clk); end
        checks++; if (dac_data !== 12'd2048) begin errors++; $display("FAIL rst_dac_data: got %0h expected 800", dac_data); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL rst_underflow: got %0b expected 0", underflow); end
        checks++; if (smp_if.sample_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b expected 1", smp_if.sample_ready); end
        @(posedge clk_400M);
        #0.5 rst = 1'b0;
        ph = 0;
        $display("reset: released");
    endtask

    task automatic test_idle_clock();
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (dac_clk !== (ph >= 2)) begin errors++; $display("FAIL idle_dac_clk: phase %0d got %0b expected %0b", ph, dac_clk, (ph >= 2)); end
            checks++; if (dac_data !== 12'd2048) begin errors++; $display("FAIL idle_dac_data: got %0h expected 800", dac_data); end
            checks++; if (smp_if.sample_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %0b expected 1", smp_if.sample_ready); end
            $display("idle: phase %0d dac_clk %0b dac_data %0h", ph, dac_clk, dac_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] vals [3];
        vals = '{12'h001, 12'h7FF, 12'hFFF};
        en = 1'b0;
        align(0);
        for (int i = 0; i < 3; i++) begin
            smp_if.sample_in    = vals[i];
            smp_if.sample_valid = 1'b1;
            tick();
            $display("b2b: pushed %0h", vals[i]);
        end
        smp_if.sample_valid = 1'b0;
        en = 1'b1;
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL b2b_level: got %0d expected 3", fifo_level); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (dac_data !== vals[i]) begin errors++; $display("FAIL b2b_slot: got %0h expected %0h", dac_data, vals[i]); end
            $display("b2b: slot dac_data %0h", dac_data);
            for (int j = 0; j < 3; j++) begin
                tick();
                checks++; if (dac_data !== vals[i]) begin errors++; $display("FAIL b2b_stable: got %0h expected %0h", dac_data, vals[i]); end
                checks++; if (dac_clk !== (ph >= 2)) begin errors++; $display("FAIL b2b_dac_clk: got %0b expected %0b", dac_clk, (ph >= 2)); end
            end
        end
    endtask

    task automatic test_underflow();
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_before: got %0b expected 0", underflow); end
        tick();
        checks++; if (dac_data !== 12'hFFF) begin errors++; $display("FAIL uf_hold: got %0h expected fff", dac_data); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %0b expected 1", underflow); end
        $display("underflow: empty slot dac_data %0h underflow %0b", dac_data, underflow);
        align(3);
        underflow_clr = 1'b1;
        tick();
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set_wins: got %0b expected 1", underflow); end
        tick();
        underflow_clr = 1'b0;
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clr: got %0b expected 0", underflow); end
        $display("underflow: after clear %0b", underflow);
        en = 1'b0;
        align(3);
        tick();
        checks++; if (dac_data !== 12'd2048) begin errors++; $display("FAIL en0_idle: got %0h expected 800", dac_data); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL en0_uf: got %0b expected 0", underflow); end
    endtask

    task automatic test_push_on_empty_slot();
        align(3);
        en = 1'b1;
        smp_if.sample_in    = 12'h0AB;
        smp_if.sample_valid = 1'b1;
        tick();
        smp_if.sample_valid = 1'b0;
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL poe_level: got %0d expected 1", fifo_level); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL poe_uf: got %0b expected 1", underflow); end
        checks++; if (dac_data !== 12'd2048) begin errors++; $display("FAIL poe_hold: got %0h expected 800", dac_data); end
        $display("push_on_slot: level %0d underflow %0b", fifo_level, underflow);
        align(3);
        tick();
        checks++; if (dac_data !== 12'h0AB) begin errors++; $display("FAIL poe_next: got %0h expected 0ab", dac_data); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL poe_drained: got %0d expected 0", fifo_level); end
        en = 1'b0;
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL poe_clr: got %0b expected 0", underflow); end
    endtask

    task automatic test_full();
        logic [2:0]  exp_lvl [6];
        logic        exp_rdy [6];
        logic [11:0] drain [4];
        exp_lvl = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        drain   = '{12'h101, 12'h102, 12'h103, 12'h1AA};
        en = 1'b0;
        align(0);
        smp_if.sample_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            smp_if.sample_in = 12'h100 + 12'((i < 4) ? i : 4);
            tick();
            checks++; if (fifo_level !== exp_lvl[i]) begin errors++; $display("FAIL full_level: push %0d got %0d expected %0d", i, fifo_level, exp_lvl[i]); end
            checks++; if (smp_if.sample_ready !== exp_rdy[i]) begin errors++; $display("FAIL full_ready: push %0d got %0b expected %0b", i, smp_if.sample_ready, exp_rdy[i]); end
            $display("full: push %0d level %0d ready %0b", i, fifo_level, smp_if.sample_ready);
        end
        smp_if.sample_in = 12'h1AA;
        en = 1'b1;
        tick();
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_hold: got %0d expected 4", fifo_level); end
        tick();
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL full_pop_no_push: got %0d expected 3", fifo_level); end
        checks++; if (dac_data !== 12'h100) begin errors++; $display("FAIL full_first: got %0h expected 100", dac_data); end
        checks++; if (smp_if.sample_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %0b expected 1", smp_if.sample_ready); end
        tick();
        smp_if.sample_valid = 1'b0;
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_refill: got %0d expected 4", fifo_level); end
        for (int i = 0; i < 4; i++) begin
            align(3);
            tick();
            checks++; if (dac_data !== drain[i]) begin errors++; $display("FAIL full_drain: got %0h expected %0h", dac_data, drain[i]); end
            $display("full: drain dac_data %0h", dac_data);
        end
        en = 1'b0;
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL full_empty: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_streaming();
        logic [11:0] exp_v;
        en = 1'b0;
        align(0);
        smp_if.sample_valid = 1'b1;
        smp_if.sample_in = 12'h010; tick();
        smp_if.sample_in = 12'h011; tick();
        smp_if.sample_valid = 1'b0;
        en = 1'b1;
        tick();
        checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL stream_pre: got %0d expected 2", fifo_level); end
        for (int s = 0; s < 4; s++) begin
            smp_if.sample_in    = 12'h012 + 12'(s);
            smp_if.sample_valid = 1'b1;
            tick();
            smp_if.sample_valid = 1'b0;
            exp_v = 12'h010 + 12'(s);
            checks++; if (dac_data !== exp_v) begin errors++; $display("FAIL stream_data: got %0h expected %0h", dac_data, exp_v); end
            $display("stream: slot dac_data %0h level %0d", dac_data, fifo_level);
            for (int j = 0; j < 4; j++) begin
                if (j > 0) tick();
                checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL stream_level: got %0d expected 2", fifo_level); end
                checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL stream_uf: got %0b expected 0", underflow); end
            end
        end
    endtask

    task automatic test_reset_mid();
        smp_if.sample_valid = 1'b1;
        smp_if.sample_in = 12'h016; tick();
        smp_if.sample_in = 12'h017; tick();
        smp_if.sample_valid = 1'b0;
        tick();
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL mid_level: got %0d expected 3", fifo_level); end
        checks++; if (dac_clk !== 1'b1) begin errors++; $display("FAIL mid_dac_clk: got %0b expected 1", dac_clk); end
        checks++; if (dac_data !== 12'h014) begin errors++; $display("FAIL mid_data: got %0h expected 014", dac_data); end
        rst = 1'b1;
        #0.2;
        checks++; if (dac_clk !== 1'b0) begin errors++; $display("FAIL mid_rst_clk: got %0b expected 0", dac_clk); end
        checks++; if (dac_data !== 12'd2048) begin errors++; $display("FAIL mid_rst_data: got %0h expected 800", dac_data); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_rst_level: got %0d expected 0", fifo_level); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL mid_rst_uf: got %0b expected 0", underflow); end
        $display("reset_mid: level %0d dac_data %0h", fifo_level, dac_data);
        @(posedge clk_400M);
        #0.5 rst = 1'b0;
        ph = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (dac_data !== 12'd2048) begin errors++; $display("FAIL post_rst_data: got %0h expected 800", dac_data); end
            checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL post_rst_uf_early: got %0b expected 0", underflow); end
            checks++; if (dac_clk !== (ph >= 2)) begin errors++; $display("FAIL post_rst_clk: got %0b expected %0b", dac_clk, (ph >= 2)); end
        end
        tick();
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL post_rst_uf: got %0b expected 1", underflow); end
        checks++; if (dac_data !== 12'd2048) begin errors++; $display("FAIL post_rst_hold: got %0h expected 800", dac_data); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL post_rst_level: got %0d expected 0", fifo_level); end
        $display("reset_mid: first slot underflow %0b", underflow);
    endtask

    initial begin
        test_reset();
        test_idle_clock();
        test_back_to_back();
        test_underflow();
        test_push_on_empty_slot();
        test_full();
        test_streaming();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
